det_share_arb: RTL and testbench
================================

# det_share_arb

Round-robin arbiter and context manager that time-shares one Moore transition-detector datapath among NCH serial bit requesters. Each cycle at most one requester's bit is accepted. That bit advances the requester's saved 3-bit detector state, and the block reports the resulting Moore output tagged with the channel ID. It sits between the per-channel serial sources and downstream match logic. It replaces NCH separate detector instances.

## Interface
- NCH, 4, number of requesters (2..8)
- IDW, 2, channel-ID width; must equal clog2(NCH)
- CNTW, 8, per-channel match-counter width (used only with DET_CNT_EN)

- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous, active-low reset (sampled on CLK rising edge)
- REQ  in  NCH  per-channel request; bit i valid on BIT[i]
- BIT  in  NCH  serial data bit per channel
- CLR  in  NCH  per-channel context clear
- GNT  out  NCH  one-hot grant, combinational from REQ, CLR and PTR
- OUT_V  out  1  registered; result valid
- OUT_ID  out  IDW  registered; channel of the result
- OUT_Z  out  1  registered; Moore output of the channel's updated state
- OUT_ST  out  3  registered; updated state code of that channel
- CNT_SEL  in  IDW  counter read select
- CNT_OUT  out  CNTW  match count of channel CNT_SEL (combinational)

## Operation
- Per-channel context CTX[i] holds a 3-bit state. Encodings:
  - START=000
  - GET0=001
  - GET1=010
  - GET01=011
  - GET10=110
- Next-state function, shared and applied only to the granted channel:
  - START: X=1 goes to GET1, X=0 goes to GET0
  - GET0: X=1 goes to GET01, X=0 goes to GET0
  - GET01: X=1 goes to GET1, X=0 goes to GET10
  - GET1: X=1 goes to GET1, X=0 goes to GET10
  - GET10: X=1 goes to GET01, X=0 goes to GET0
  - any illegal code goes to START
- Z=1 iff the updated state is GET01 or GET10, i.e. the last two accepted bits differ.
- Arbitration:
  - Eligible channels satisfy REQ[i]=1 and CLR[i]=0.
  - Search starts at PTR and proceeds upward, wrapping modulo NCH. The first eligible channel gets GNT.
  - After a grant to channel i, PTR becomes (i+1) mod NCH.
  - With no eligible channel, GNT is all zero and PTR holds.
- Transfer occurs when GNT[i]=1; GNT implies REQ. CTX[i] takes the next state at that edge.
- CLR[i]=1 forces CTX[i]=START at the edge and blocks the grant for that cycle. The bit is not consumed; the requester holds REQ.
- Channels not granted and not cleared keep their context unchanged.
- Reset values:
  - every CTX = START
  - PTR = 0
  - OUT_V, OUT_ID, OUT_Z, OUT_ST = 0
  - counters = 0
- Out-of-range channel indices (NCH not a power of two): never granted. CNT_SEL ≥ NCH returns 0.

## Timing
- GNT is valid in the same cycle as REQ, with zero-cycle latency.
- The OUT_* result appears in the cycle after the transfer edge and lasts one cycle. OUT_V=0 in any cycle following no transfer.
- A channel can be granted in back-to-back cycles only if it is the sole eligible requester. With k eligible channels, each is served at least once every k cycles.
- CLR on channel A together with a grant to channel B: both take effect at the same edge.
- RST_N low overrides everything at the next edge: no result emitted and the pending transfer is dropped. OUT_V=0 in the cycle after reset.
- CNT_OUT reflects the count updated at the most recent edge.

## Configuration
- DET_CNT_EN defined:
  - Each channel has a CNTW-bit counter.
  - The counter increments at a transfer edge when the updated state has Z=1.
  - It saturates at 2^CNTW−1.
  - CLR[i] or reset zeroes it; clear wins over an increment in the same cycle.
- DET_CNT_EN undefined: no counters are synthesized, CNT_OUT is tied to 0 and CNT_SEL is ignored.

## Test plan
- Reset, then a single requester: REQ=0001 with BIT[0] stream 0,1,1,0 → GNT=0001 every cycle; OUT_ST sequence 001,011,010,110; OUT_Z 0,1,0,1; OUT_ID=0.
- All four requesting for 8 cycles, PTR=0 → GNT order 0001,0010,0100,1000,0001…; each channel's context evolves independently. Check interleaved streams 0,1 on ch0 and 1,1 on ch1: ch0 Z=1 on its 2nd grant, ch1 Z=0.
- REQ=0101 after a grant to ch2 (PTR=3) → next GNT=0001, PTR=1.
- CLR[1]=1 with REQ=0010 → GNT=0000, OUT_V=0 next cycle, CTX[1]=START. The next grant with BIT=1 gives OUT_ST=010.
- RST_N=0 mid-stream with ch3 in GET10 → next cycle OUT_V=0, then first grant to ch3 with BIT=0 gives OUT_ST=001. An illegal CTX code forced by the bench recovers to START.
- DET_CNT_EN with CNTW=2: alternate 0/1 on ch0 for 6 bits → CNT_OUT (CNT_SEL=0) reads 1,2,3,3,3, saturating. CLR[0] → 0. Without the macro, CNT_OUT=0 throughout.

Source files
------------

// File: rtl/det_share_arb.sv
// det_share_arb: round-robin arbiter sharing one Moore transition detector.
// Define DET_CNT_EN to add per-channel saturating match counters.
module det_share_arb #(
  parameter int NCH  = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NCH-1:0]  REQ,
  input  logic [NCH-1:0]  BIT,
  input  logic [NCH-1:0]  CLR,
  output logic [NCH-1:0]  GNT,
  output logic            OUT_V,
  output logic [IDW-1:0]  OUT_ID,
  output logic            OUT_Z,
  output logic [2:0]      OUT_ST,
  input  logic [IDW-1:0]  CNT_SEL,
  output logic [CNTW-1:0] CNT_OUT
);

  typedef enum logic [2:0] {
    START = 3'b000,
    GET0  = 3'b001,
    GET1  = 3'b010,
    GET01 = 3'b011,
    GET10 = 3'b110
  } st_t;

  function automatic logic [2:0] nxt(
    input logic [2:0] s,
    input logic       x
  );
    case (s)
      START:   nxt = x ? GET1  : GET0;
      GET0:    nxt = x ? GET01 : GET0;
      GET01:   nxt = x ? GET1  : GET10;
      GET1:    nxt = x ? GET1  : GET10;
      GET10:   nxt = x ? GET01 : GET0;
      default: nxt = START;
    endcase
  endfunction

  logic [NCH-1:0][2:0] ctx_q;
  logic [NCH-1:0][2:0] ctx_d;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      gidx;
  logic [IDW-1:0]      idx;
  logic [NCH-1:0]      gnt;
  logic                gv;
  logic [2:0]          gst;
  logic                gz;

  assign GNT = gnt;

  // first eligible channel searching upward from ptr, with wrap
  always_comb begin
    gnt  = '0;
    gv   = 1'b0;
    gidx = '0;
    idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NCH);
      if (!gv && REQ[idx] && !CLR[idx]) begin
        gv       = 1'b1;
        gidx     = idx;
        gnt[idx] = 1'b1;
      end
    end
    gst = nxt(ctx_q[gidx], BIT[gidx]);
    gz  = (gst == GET01) || (gst == GET10);
  end

  // per-channel context: clear to START, else advance on grant
  always_comb begin
    ctx_d = ctx_q;
    for (int i = 0; i < NCH; i++) begin
      if (CLR[i])
        ctx_d[i] = START;
      else if (gnt[i])
        ctx_d[i] = nxt(ctx_q[i], BIT[i]);
    end
  end

  // context, pointer and registered result
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ctx_q  <= '0;
      ptr_q  <= '0;
      OUT_V  <= 1'b0;
      OUT_ID <= '0;
      OUT_Z  <= 1'b0;
      OUT_ST <= '0;
    end else begin
      ctx_q  <= ctx_d;
      if (gv)
        ptr_q <= IDW'((int'(gidx) + 1) % NCH);
      OUT_V  <= gv;
      OUT_ID <= gidx;
      OUT_Z  <= gz;
      OUT_ST <= gst;
    end
  end

`ifdef DET_CNT_EN
  logic [NCH-1:0][CNTW-1:0] cnt_q;

  // saturating match counters; clear beats increment
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (CLR[i])
          cnt_q[i] <= '0;
        else if (gnt[i] && gz && (cnt_q[i] != {CNTW{1'b1}}))
          cnt_q[i] <= cnt_q[i] + CNTW'(1);
      end
    end
  end

  // read port; selects beyond the channel count read zero
  assign CNT_OUT = (int'(CNT_SEL) < NCH) ? cnt_q[CNT_SEL] : '0;
`else
  logic unused_sel;

  assign unused_sel = ^CNT_SEL;
  assign CNT_OUT    = '0;
`endif

endmodule

// File: tb/tb_det_share_arb.sv
// tb_det_share_arb: directed and random checks of det_share_arb
// against a bit-history reference model.
module tb_det_share_arb;

  localparam int NCH  = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  req, bits, clr, gnt;
  logic            out_v, out_z;
  logic [IDW-1:0]  out_id, cnt_sel;
  logic [2:0]      out_st;
  logic [CNTW-1:0] cnt_out;

  int ncmp = 0;
  int nfail = 0;

  int   hn [NCH];
  logic hl [NCH];
  logic hp [NCH];
  int   mcnt [NCH];
  int   mptr;
  logic [NCH-1:0] gnt_seen;

  always #5 clk = ~clk;

  det_share_arb #(.NCH(NCH), .IDW(IDW), .CNTW(CNTW)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .BIT(bits), .CLR(clr),
    .GNT(gnt), .OUT_V(out_v), .OUT_ID(out_id), .OUT_Z(out_z),
    .OUT_ST(out_st), .CNT_SEL(cnt_sel), .CNT_OUT(cnt_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // state implied by the last two accepted bits
  function automatic logic [2:0] mstate(input int n, input logic p,
                                        input logic l);
    if (n == 0) return 3'b000;
    if (n == 1 || p == l) return l ? 3'b010 : 3'b001;
    return l ? 3'b011 : 3'b110;
  endfunction

  task automatic cycle(input logic [NCH-1:0] rq, input logic [NCH-1:0] bt,
                       input logic [NCH-1:0] cl, input logic rs,
                       input int sel);
    int g;
    int idx;
    int ecnt;
    logic [2:0] st;
    @(negedge clk);
    req = rq; bits = bt; clr = cl; rst_n = rs;
    cnt_sel = IDW'(sel);
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      idx = (mptr + k) % NCH;
      if (g < 0 && rq[idx] && !cl[idx]) g = idx;
    end
    #1;
    gnt_seen = gnt;
    if (rs) chk("gnt", gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    #1;
    if (!rs) begin
      for (int i = 0; i < NCH; i++) begin
        hn[i] = 0;
        mcnt[i] = 0;
      end
      mptr = 0;
      chk("rst_v", out_v, 0);
      chk("rst_id", out_id, 0);
      chk("rst_z", out_z, 0);
      chk("rst_st", out_st, 0);
    end else begin
      for (int i = 0; i < NCH; i++)
        if (cl[i]) begin
          hn[i] = 0;
          mcnt[i] = 0;
        end
      if (g >= 0) begin
        hp[g] = hl[g];
        hl[g] = bt[g];
        if (hn[g] < 2) hn[g]++;
        st = mstate(hn[g], hp[g], hl[g]);
        if (hn[g] >= 2 && hp[g] != hl[g] && mcnt[g] < CMAX) mcnt[g]++;
        mptr = (g + 1) % NCH;
        chk("v", out_v, 1);
        chk("id", out_id, g);
        chk("st", out_st, st);
        chk("z", out_z, (hn[g] >= 2 && hp[g] != hl[g]) ? 1 : 0);
      end else begin
        chk("v_idle", out_v, 0);
      end
    end
`ifdef DET_CNT_EN
    ecnt = (sel < NCH) ? mcnt[sel] : 0;
`else
    ecnt = 0;
`endif
    chk("cnt", cnt_out, ecnt);
  endtask

  initial begin
    int exp;
    for (int i = 0; i < NCH; i++) begin
      hn[i] = 0; hl[i] = 0; hp[i] = 0; mcnt[i] = 0;
    end
    mptr = 0;
    rst_n = 0; req = 0; bits = 0; clr = 0; cnt_sel = 0;

    cycle(4'b0000, 4'b0000, 4'b0000, 0, 0);
    cycle(4'b0000, 4'b0000, 4'b0000, 0, 0);

    // single requester, stream 0,1,1,0
    cycle(4'b0001, 4'b0000, 4'b0000, 1, 0);
    chk("t1_st0", out_st, 3'b001);
    cycle(4'b0001, 4'b0001, 4'b0000, 1, 0);
    chk("t1_st1", out_st, 3'b011);
    chk("t1_z1", out_z, 1);
    cycle(4'b0001, 4'b0001, 4'b0000, 1, 0);
    chk("t1_st2", out_st, 3'b010);
    cycle(4'b0001, 4'b0000, 4'b0000, 1, 0);
    chk("t1_st3", out_st, 3'b110);
    chk("t1_gnt", gnt_seen, 4'b0001);

    // all four requesting from ptr 0
    cycle(4'b0000, 4'b0000, 4'b0000, 0, 0);
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, (c < 4) ? 4'b0010 : 4'b0011, 4'b0000, 1, 0);
      chk("t2_gnt", gnt_seen, 4'b0001 << (c % 4));
      if (c == 4) chk("t2_ch0_z", out_z, 1);
      if (c == 5) chk("t2_ch1_z", out_z, 0);
    end

    // pointer wrap after grant to ch2
    cycle(4'b0100, 4'b0000, 4'b0000, 1, 1);
    cycle(4'b0101, 4'b0000, 4'b0000, 1, 2);
    chk("t3_gnt0", gnt_seen, 4'b0001);
    cycle(4'b0101, 4'b0000, 4'b0000, 1, 3);
    chk("t3_gnt2", gnt_seen, 4'b0100);

    // clear blocks grant and resets context
    cycle(4'b0010, 4'b0000, 4'b0010, 1, 1);
    chk("t4_gnt", gnt_seen, 4'b0000);
    chk("t4_v", out_v, 0);
    cycle(4'b0010, 4'b0010, 4'b0000, 1, 1);
    chk("t4_st", out_st, 3'b010);

    // reset mid-stream with ch3 in GET10
    cycle(4'b1000, 4'b1000, 4'b0000, 1, 3);
    cycle(4'b1000, 4'b0000, 4'b0000, 1, 3);
    chk("t5_get10", out_st, 3'b110);
    cycle(4'b1000, 4'b0000, 4'b0000, 0, 3);
    chk("t5_v", out_v, 0);
    cycle(4'b1000, 4'b0000, 4'b0000, 1, 3);
    chk("t5_st", out_st, 3'b001);

    // illegal context code recovers to START
    cycle(4'b0000, 4'b0000, 4'b1111, 1, 0);
    @(negedge clk);
    force dut.ctx_q = 12'hE00;
    req = 4'b1000; bits = 4'b1000; clr = 4'b0000; rst_n = 1;
    #1;
    chk("t6_gnt", gnt, 4'b1000);
    @(posedge clk);
    #1;
    chk("t6_v", out_v, 1);
    chk("t6_id", out_id, 3);
    chk("t6_st", out_st, 3'b000);
    chk("t6_z", out_z, 0);
    release dut.ctx_q;
    mptr = 0;
    cycle(4'b0000, 4'b0000, 4'b1000, 1, 3);
    cycle(4'b1000, 4'b1000, 4'b0000, 1, 3);
    chk("t6_st1", out_st, 3'b010);

    // counter saturation and clear
    cycle(4'b0000, 4'b0000, 4'b0000, 0, 0);
    for (int b = 0; b < 6; b++) begin
      cycle(4'b0001, (b % 2) ? 4'b0001 : 4'b0000, 4'b0000, 1, 0);
`ifdef DET_CNT_EN
      exp = (b < 3) ? b : 3;
`else
      exp = 0;
`endif
      chk("t7_cnt", cnt_out, exp);
    end
    cycle(4'b0000, 4'b0000, 4'b0001, 1, 0);
    chk("t7_clr", cnt_out, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(4'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
            ($urandom_range(0, 59) != 0), $urandom_range(0, NCH - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
